// File: rtl/ddr_upload_adaptor.sv
// ddr_upload_adaptor
// Serves byte-wide HPS upload reads from a DDR3 window. Each DDR access is a
// single 64-bit beat. A one-word line buffer holds the last fetched word, so a
// sequential read stream needs DDR traffic for only one byte in eight.
module ddr_upload_adaptor #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [24:0] SIZE      = 25'h20_0000,
  parameter logic [7:0]  INDEX     = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_upload_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        ddr_acquire,
  output logic [31:0] ddr_addr,
  output logic        ddr_read,
  output logic [7:0]  ddr_burstcnt,
  output logic [7:0]  ddr_byteenable,
  output logic        ddr_write,
  output logic [63:0] ddr_wdata,
  input  logic [63:0] ddr_rdata,
  input  logic        ddr_rdata_ready,
  input  logic        ddr_busy
);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        active;
  logic        active_q;
  logic        act_rise;

  logic [63:0] buf_data;
  logic [21:0] buf_tag;
  logic        buf_valid;
  logic [24:0] addr_q;
  logic        fetch_abort;

  logic        rd_oor;
  logic        rd_hit;
  logic        rd_miss;
  logic        fill;
  logic        buf_match;

  // Little-endian byte lane select within a 64-bit word.
  function automatic logic [7:0] sel_byte(input logic [63:0] word, input logic [2:0] n);
    sel_byte = word[{n, 3'b000} +: 8];
  endfunction

  assign active         = ioctl_upload & (ioctl_upload_index == INDEX);
  assign act_rise       = active & ~active_q;
  assign ddr_acquire    = active | (state != IDLE);

  assign ddr_burstcnt   = 8'd1;
  assign ddr_byteenable = 8'hFF;
  assign ddr_write      = 1'b0;
  assign ddr_wdata      = 64'd0;

  // A buffer that is being invalidated this very cycle must not produce a hit.
  assign buf_match = buf_valid & ~act_rise & (buf_tag == ioctl_addr[24:3]);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_nxt = state;
    rd_oor    = 1'b0;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (ioctl_rd && active) begin
          if (ioctl_addr >= SIZE) begin
            rd_oor = 1'b1;
          end else if (buf_match) begin
            rd_hit = 1'b1;
          end else begin
            rd_miss   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (!ddr_busy) state_nxt = DATA;
      end
      DATA: begin
        if (ddr_rdata_ready) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Upload-active history, used to detect the start of a new upload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) active_q <= 1'b0;
    else       active_q <= active;
  end

  // Avalon read request: raised on a miss, held until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr_read <= 1'b0;
      ddr_addr <= 32'd0;
    end else if (rd_miss) begin
      ddr_read <= 1'b1;
      ddr_addr <= BASE_ADDR + {7'd0, ioctl_addr[24:3], 3'b000};
    end else if (state == REQ && !ddr_busy) begin
      ddr_read <= 1'b0;
    end
  end

  // HPS-facing read data and stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
    end else begin
      if (rd_oor)       ioctl_din <= 8'h00;
      else if (rd_hit)  ioctl_din <= sel_byte(buf_data, ioctl_addr[2:0]);
      else if (fill)    ioctl_din <= sel_byte(ddr_rdata, addr_q[2:0]);
      if (rd_miss)      ioctl_wait <= 1'b1;
      else if (fill)    ioctl_wait <= 1'b0;
    end
  end

  // Remembers whether the upload went away while a fetch was outstanding,
  // so the returning word is not trusted for later hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              fetch_abort <= 1'b0;
    else if (rd_miss)                       fetch_abort <= 1'b0;
    else if (state != IDLE && !active)      fetch_abort <= 1'b1;
  end

  // Line buffer valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         buf_valid <= 1'b0;
    else if (act_rise) buf_valid <= 1'b0;
    else if (fill)     buf_valid <= ~(fetch_abort | ~active);
  end

  // Line buffer contents and the address of the outstanding miss.
  always_ff @(posedge clk) begin
    if (rd_miss) addr_q <= ioctl_addr;
    if (fill) begin
      buf_data <= ddr_rdata;
      buf_tag  <= addr_q[24:3];
    end
  end

endmodule

// File: doc/ddr_upload_adaptor.md
Name: ddr_upload_adaptor

Overview:
- Serves HPS upload reads (ioctl_upload / ioctl_rd / ioctl_din) from a region of DDR3, in the reverse direction of the ROM download path.
- Converts byte-addressed ioctl reads into single-beat 64-bit DDR reads.
- Keeps a one-word line buffer so that 7 of every 8 sequential bytes are served without DDR traffic.
- Drives its own ddr_if master port, which is arbitrated by an upstream ddr_mux.

Parameters:
- BASE_ADDR, 32'h3000_0000, DDR byte address of upload byte 0 (8-byte aligned).
- SIZE, 25'h20_0000, region length in bytes; reads at or beyond this return 8'h00.
- INDEX, 8'd3, ioctl_upload_index value this block responds to.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_upload  in  1  upload active
- ioctl_upload_index  in  8  upload slot index
- ioctl_rd  in  1  one-cycle byte read strobe
- ioctl_addr  in  25  byte offset of the read
- ioctl_din  out  8  read data
- ioctl_wait  out  1  stall request to HPS
- ddr_acquire  out  1  request ownership of the DDR mux
- ddr_addr  out  32  DDR byte address (8-byte aligned)
- ddr_read  out  1  Avalon read request
- ddr_burstcnt  out  8  fixed 8'd1
- ddr_byteenable  out  8  fixed 8'hFF
- ddr_write  out  1  fixed 0
- ddr_wdata  out  64  fixed 0
- ddr_rdata  in  64  read data
- ddr_rdata_ready  in  1  read data valid
- ddr_busy  in  1  Avalon waitrequest

Behaviour:
- Selection: active = ioctl_upload & (ioctl_upload_index == INDEX).
  - ddr_acquire = active | (state != IDLE).
- Reset values: ioctl_din=0, ioctl_wait=0, ddr_read=0, ddr_addr=0, buffer valid=0, state=IDLE.
- Line buffer: 64-bit data plus 22-bit tag (ioctl_addr[24:3]) plus a valid bit.
  - Byte select is little-endian: byte n = data[8n+7:8n], with n = ioctl_addr[2:0].
- Invalidation: valid clears on the rising edge of active and on reset.
- States: IDLE, REQ, DATA.
- IDLE, ioctl_rd sampled with active=1:
  - ioctl_addr >= SIZE: ioctl_din <= 8'h00 next cycle, no DDR access.
  - Hit (valid and tag match): ioctl_din <= selected byte next cycle, no DDR access. Latency is 1 cycle.
  - Miss: latch the address; ioctl_wait <= 1; ddr_addr <= BASE_ADDR + {ioctl_addr[24:3],3'b000}; ddr_read <= 1; go to REQ.
- ioctl_rd with active=0: ignored; ioctl_din holds its value; no wait.
- REQ:
  - Hold ddr_read and ddr_addr stable while ddr_busy=1.
  - On the first cycle with ddr_busy=0, drop ddr_read next cycle and go to DATA.
- DATA:
  - On ddr_rdata_ready: buffer <= ddr_rdata; tag <= latched address; valid <= 1; ioctl_din <= selected byte of ddr_rdata; ioctl_wait <= 0; go to IDLE.
  - Miss latency = DDR latency + 2 cycles. ioctl_din is valid in the cycle ioctl_wait falls.
- ioctl_rd while state != IDLE is a protocol violation and is ignored: no state change, no extra request.
- ioctl_upload falls mid-fetch: the outstanding Avalon read still completes (REQ→DATA→IDLE, rdata consumed). The buffer is then left invalid and ioctl_wait clears. An Avalon transaction is never abandoned.
- Reset mid-fetch: immediate return to IDLE with all outputs at reset values. Any stray ddr_rdata_ready arriving in IDLE is ignored.
- Address arithmetic: 32-bit, with no wrap check beyond SIZE. BASE_ADDR + SIZE must not exceed 2^32; this is a parameter constraint.

Test Plan:
- DDR model holding 64'h0807_0605_0403_0201 at BASE_ADDR, 5-cycle read latency; upload index 3; rd addr 0 → ioctl_wait high 1 cycle after rd, one ddr_read at 32'h3000_0000, wait falls with ioctl_din=8'h01, about 7 cycles total.
- Follow-up rd at addr 1..7 → ioctl_din = 8'h02..8'h08, each 1 cycle after rd, zero ddr_read pulses, ioctl_wait stays 0.
- rd at addr 8 → miss, ddr_addr=32'h3000_0008; ddr_busy held high 4 cycles → ddr_read and ddr_addr stable throughout, exactly one accepted request.
- rd at addr 25'h20_0000 (=SIZE) → ioctl_din=8'h00, no DDR access, no wait. rd with ioctl_upload_index=4 → ioctl_din unchanged, ddr_acquire=0.
- Drop ioctl_upload during DATA, then restart the upload and rd addr 0 → first transaction completes cleanly and ioctl_wait clears; after restart a fresh DDR read occurs (buffer invalidated).
- Assert reset during REQ → ddr_read=0, ioctl_wait=0, ioctl_din=0 asynchronously. A late ddr_rdata_ready is ignored; the next rd at addr 0 misses.
